// File: rtl/ifu_fetch_pkg.sv
// Shared types for the instruction fetch unit.
// Reset PC, nop encoding and FSM state encoding.
package ifu_fetch_pkg;

  localparam logic [31:0] DEF_RESET_PC = 32'h8000_0000;
  localparam logic [31:0] NOP_INST     = 32'h0000_0013;

  localparam logic [2:0] ST_REQ   = 3'd0;
  localparam logic [2:0] ST_WAIT  = 3'd1;
  localparam logic [2:0] ST_HOLD  = 3'd2;
  localparam logic [2:0] ST_DROP  = 3'd3;
  localparam logic [2:0] ST_FAULT = 3'd4;

  typedef enum logic [2:0] {
    S_REQ   = ST_REQ,
    S_WAIT  = ST_WAIT,
    S_HOLD  = ST_HOLD,
    S_DROP  = ST_DROP,
    S_FAULT = ST_FAULT
  } state_e;

  function automatic logic misaligned(input logic [31:0] a);
    return |a[1:0];
  endfunction

endpackage

// File: rtl/ifu_fetch_if.sv
// Fetch unit bus: imem request/response, decoder
// handshake, redirect input and fault flag.
interface ifu_fetch_if;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        imem_rsp_err;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        fetch_fault;

  modport master (
    output imem_req_valid, imem_req_addr,
    output inst_valid, inst, inst_pc,
    output fetch_fault,
    input  imem_req_ready, imem_rsp_valid,
    input  imem_rsp_data, imem_rsp_err,
    input  inst_ready,
    input  redirect_valid, redirect_pc
  );

  modport slave (
    input  imem_req_valid, imem_req_addr,
    input  inst_valid, inst, inst_pc,
    input  fetch_fault,
    output imem_req_ready, imem_rsp_valid,
    output imem_rsp_data, imem_rsp_err,
    output inst_ready,
    output redirect_valid, redirect_pc
  );
endinterface

// File: rtl/ifu_pc_reg.sv
// Program counter register with load and +4.
// Load wins over increment; wraps modulo 2^32.
module ifu_pc_reg #(
  parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load_i,
  input  logic [31:0] load_pc_i,
  input  logic        inc_i,
  output logic [31:0] pc_o
);

  logic [31:0] pc_q;
  logic [31:0] pc_d;

  // Next PC: redirect load, sequential step, or hold.
  always_comb begin
    pc_d = pc_q;
    if (load_i)     pc_d = load_pc_i;
    else if (inc_i) pc_d = pc_q + 32'd4;
  end

  // PC register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) pc_q <= RESET_PC;
    else     pc_q <= pc_d;
  end

  assign pc_o = pc_q;

endmodule

// File: rtl/ifu_fetch.sv
// Instruction fetch unit: one outstanding fetch,
// redirect handling and sticky access fault.
module ifu_fetch
  import ifu_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEF_RESET_PC
) (
  input  logic        clk,
  input  logic        rst,
  ifu_fetch_if.master bus
);

  state_e      state_q;
  state_e      state_d;
  logic [31:0] inst_q;
  logic [31:0] inst_d;
  logic [31:0] ipc_q;
  logic [31:0] ipc_d;
  logic [31:0] pc;
  logic        pc_ld;
  logic        pc_inc;
  logic        redir;
  logic        bad;

  assign redir = bus.redirect_valid;
  assign bad   = misaligned(bus.redirect_pc);

  ifu_pc_reg #(.RESET_PC(RESET_PC)) u_pc (
    .clk       (clk),
    .rst       (rst),
    .load_i    (pc_ld),
    .load_pc_i (bus.redirect_pc),
    .inc_i     (pc_inc),
    .pc_o      (pc)
  );

  // State, presented instruction and its PC.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_REQ;
      inst_q  <= NOP_INST;
      ipc_q   <= RESET_PC;
    end else begin
      state_q <= state_d;
      inst_q  <= inst_d;
      ipc_q   <= ipc_d;
    end
  end

  // Next state; a redirect beats every other event,
  // and a misaligned target ends in FAULT.
  always_comb begin
    state_d = state_q;
    inst_d  = inst_q;
    ipc_d   = ipc_q;
    pc_ld   = 1'b0;
    pc_inc  = 1'b0;
    unique case (state_q)
      S_REQ: begin
        if (redir) begin
          pc_ld = !bad;
          if (bad)
            state_d = S_FAULT;
          else if (bus.imem_req_ready)
            state_d = S_DROP;
        end else if (bus.imem_req_ready) begin
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (redir) begin
          pc_ld = !bad;
          if (bad)
            state_d = S_FAULT;
          else if (bus.imem_rsp_valid)
            state_d = S_REQ;
          else
            state_d = S_DROP;
        end else if (bus.imem_rsp_valid) begin
          if (bus.imem_rsp_err) begin
            state_d = S_FAULT;
          end else begin
            inst_d  = bus.imem_rsp_data;
            ipc_d   = pc;
            state_d = S_HOLD;
          end
        end
      end
      S_HOLD: begin
        if (redir) begin
          pc_ld   = !bad;
          state_d = bad ? S_FAULT : S_REQ;
        end else if (bus.inst_ready) begin
          pc_inc  = 1'b1;
          state_d = S_REQ;
        end
      end
      S_DROP: begin
        if (redir) begin
          pc_ld = !bad;
          if (bad)
            state_d = S_FAULT;
          else if (bus.imem_rsp_valid)
            state_d = S_REQ;
        end else if (bus.imem_rsp_valid) begin
          state_d = S_REQ;
        end
      end
      S_FAULT: state_d = S_FAULT;
      default: state_d = S_FAULT;
    endcase
  end

  assign bus.imem_req_valid = (state_q == S_REQ);
  assign bus.imem_req_addr  = pc;
  assign bus.inst_valid     = (state_q == S_HOLD);
  assign bus.inst           = inst_q;
  assign bus.inst_pc        = ipc_q;
  assign bus.fetch_fault    = (state_q == S_FAULT);

endmodule

// File: tb/tb_ifu_fetch.sv
// Directed bench for ifu_fetch.
// Inputs change and outputs are sampled 1ns after posedge.
module tb_ifu_fetch;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  ifu_fetch_if bus();

  ifu_fetch dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.imem_req_ready = 1'b0;
    bus.imem_rsp_valid = 1'b0;
    bus.imem_rsp_data  = 32'h0;
    bus.imem_rsp_err   = 1'b0;
    bus.inst_ready     = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = 32'h0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // REQ -> WAIT -> HOLD with data d; leaves the FSM in HOLD.
  task automatic fetch_to_hold(input logic [31:0] d);
    bus.imem_req_ready = 1'b1;
    step();
    bus.imem_req_ready = 1'b0;
    bus.imem_rsp_valid = 1'b1;
    bus.imem_rsp_data  = d;
    step();
    bus.imem_rsp_valid = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    chk("rst_req_valid", 32'(bus.imem_req_valid), 32'd1);
    chk("rst_addr", bus.imem_req_addr, 32'h8000_0000);
    chk("rst_inst", bus.inst, 32'h0000_0013);
    chk("rst_inst_pc", bus.inst_pc, 32'h8000_0000);
    chk("rst_fault", 32'(bus.fetch_fault), 32'd0);
    chk("rst_inst_valid", 32'(bus.inst_valid), 32'd0);
  endtask

  task automatic test_basic();
    bus.imem_req_ready = 1'b1;
    step();
    bus.imem_req_ready = 1'b0;
    chk("wait_req_valid", 32'(bus.imem_req_valid), 32'd0);
    chk("wait_inst_valid", 32'(bus.inst_valid), 32'd0);
    bus.imem_rsp_valid = 1'b1;
    bus.imem_rsp_data  = 32'h0050_0093;
    step();
    bus.imem_rsp_valid = 1'b0;
    chk("hold_inst_valid", 32'(bus.inst_valid), 32'd1);
    chk("hold_inst", bus.inst, 32'h0050_0093);
    chk("hold_inst_pc", bus.inst_pc, 32'h8000_0000);
    chk("hold_req_valid", 32'(bus.imem_req_valid), 32'd0);
    bus.inst_ready = 1'b1;
    step();
    bus.inst_ready = 1'b0;
    chk("next_req_valid", 32'(bus.imem_req_valid), 32'd1);
    chk("next_addr", bus.imem_req_addr, 32'h8000_0004);
    chk("next_inst_valid", 32'(bus.inst_valid), 32'd0);
  endtask

  task automatic test_redirect_wait();
    bus.imem_req_ready = 1'b1;
    step();
    bus.imem_req_ready = 1'b0;
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h8000_0100;
    step();
    bus.redirect_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      chk("drop_req_valid", 32'(bus.imem_req_valid), 32'd0);
      chk("drop_inst_valid", 32'(bus.inst_valid), 32'd0);
      step();
    end
    bus.imem_rsp_valid = 1'b1;
    bus.imem_rsp_data  = 32'hDEAD_BEEF;
    bus.imem_rsp_err   = 1'b1;
    step();
    bus.imem_rsp_valid = 1'b0;
    bus.imem_rsp_err   = 1'b0;
    chk("rw_req_valid", 32'(bus.imem_req_valid), 32'd1);
    chk("rw_addr", bus.imem_req_addr, 32'h8000_0100);
    chk("rw_inst_valid", 32'(bus.inst_valid), 32'd0);
    chk("rw_fault", 32'(bus.fetch_fault), 32'd0);
    chk("rw_inst_kept", bus.inst, 32'h0050_0093);
  endtask

  task automatic test_redirect_wait_rsp();
    bus.imem_req_ready = 1'b1;
    step();
    bus.imem_req_ready = 1'b0;
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h8000_0180;
    bus.imem_rsp_valid = 1'b1;
    bus.imem_rsp_err   = 1'b1;
    step();
    idle_inputs();
    chk("rwr_req_valid", 32'(bus.imem_req_valid), 32'd1);
    chk("rwr_addr", bus.imem_req_addr, 32'h8000_0180);
    chk("rwr_fault", 32'(bus.fetch_fault), 32'd0);
  endtask

  task automatic test_redirect_hold();
    fetch_to_hold(32'h0000_0033);
    chk("rh_inst_valid", 32'(bus.inst_valid), 32'd1);
    chk("rh_inst_pc", bus.inst_pc, 32'h8000_0180);
    bus.inst_ready     = 1'b1;
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h8000_0200;
    step();
    idle_inputs();
    chk("rh_next_inst_valid", 32'(bus.inst_valid), 32'd0);
    chk("rh_req_valid", 32'(bus.imem_req_valid), 32'd1);
    chk("rh_addr", bus.imem_req_addr, 32'h8000_0200);
  endtask

  task automatic test_redirect_req();
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h8000_0300;
    step();
    bus.redirect_valid = 1'b0;
    chk("rr_stay_req", 32'(bus.imem_req_valid), 32'd1);
    chk("rr_addr", bus.imem_req_addr, 32'h8000_0300);
    bus.imem_req_ready = 1'b1;
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h8000_0400;
    step();
    idle_inputs();
    chk("rr_drop_req", 32'(bus.imem_req_valid), 32'd0);
    step();
    chk("rr_drop_wait", 32'(bus.imem_req_valid), 32'd0);
    bus.imem_rsp_valid = 1'b1;
    bus.imem_rsp_err   = 1'b1;
    step();
    idle_inputs();
    chk("rr_after_drop", 32'(bus.imem_req_valid), 32'd1);
    chk("rr_after_addr", bus.imem_req_addr, 32'h8000_0400);
    chk("rr_no_fault", 32'(bus.fetch_fault), 32'd0);
  endtask

  task automatic test_stall();
    fetch_to_hold(32'h1234_5678);
    for (int i = 0; i < 10; i++) begin
      chk("st_inst", bus.inst, 32'h1234_5678);
      chk("st_inst_pc", bus.inst_pc, 32'h8000_0400);
      chk("st_inst_valid", 32'(bus.inst_valid), 32'd1);
      chk("st_req_valid", 32'(bus.imem_req_valid), 32'd0);
      step();
    end
    bus.inst_ready = 1'b1;
    step();
    bus.inst_ready = 1'b0;
    chk("st_next_addr", bus.imem_req_addr, 32'h8000_0404);
  endtask

  task automatic test_wrap();
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'hFFFF_FFFC;
    step();
    bus.redirect_valid = 1'b0;
    fetch_to_hold(32'h0000_0013);
    chk("wr_inst_pc", bus.inst_pc, 32'hFFFF_FFFC);
    bus.inst_ready = 1'b1;
    step();
    bus.inst_ready = 1'b0;
    chk("wr_addr", bus.imem_req_addr, 32'h0000_0000);
    chk("wr_req_valid", 32'(bus.imem_req_valid), 32'd1);
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h8000_0102;
    step();
    idle_inputs();
    chk("mis_fault", 32'(bus.fetch_fault), 32'd1);
    chk("mis_req_valid", 32'(bus.imem_req_valid), 32'd0);
  endtask

  task automatic test_fault();
    do_reset();
    bus.imem_req_ready = 1'b1;
    step();
    bus.imem_req_ready = 1'b0;
    bus.imem_rsp_valid = 1'b1;
    bus.imem_rsp_err   = 1'b1;
    step();
    chk("flt_set", 32'(bus.fetch_fault), 32'd1);
    for (int i = 0; i < 20; i++) begin
      bus.imem_req_ready = 1'b1;
      bus.inst_ready     = 1'b1;
      bus.imem_rsp_valid = i[0];
      bus.imem_rsp_err   = 1'b0;
      bus.redirect_valid = (i % 5 == 2);
      bus.redirect_pc    = 32'h8000_0500;
      chk("flt_req_valid", 32'(bus.imem_req_valid), 32'd0);
      chk("flt_inst_valid", 32'(bus.inst_valid), 32'd0);
      chk("flt_sticky", 32'(bus.fetch_fault), 32'd1);
      step();
    end
    do_reset();
    chk("flt_clear", 32'(bus.fetch_fault), 32'd0);
    chk("flt_rst_addr", bus.imem_req_addr, 32'h8000_0000);
    chk("flt_rst_req", 32'(bus.imem_req_valid), 32'd1);
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_basic();
    test_redirect_wait();
    test_redirect_wait_rsp();
    test_redirect_hold();
    test_redirect_req();
    test_stall();
    test_wrap();
    test_fault();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
